serial_deserializer: RTL and testbench

- Receive end of the 4-bit shifting register's serial output: samples the serial bit stream, reassembles WIDTH-bit words in either bit order, and presents each word with a VALID/ACK handshake.
- Sits downstream of the shift register's serial-out in the top-level datapath.
- The bench scoreboard uses it to check serial transfers against parallel-loaded data.

---
 rtl/serial_deserializer_pkg.sv | 20 ++
 rtl/serial_deserializer_bit_counter.sv | 33 +++
 rtl/serial_deserializer.sv | 139 +++++++++++++
 tb/tb_serial_deserializer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_deserializer_pkg.sv
// Shared definitions for the serial deserializer: FSM state encoding,
// bit-order constants and the counter-width helper.
package serial_deserializer_pkg;

   // Receiver states: waiting for a frame start, or collecting bits.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } state_t;

   // Bit order as presented on the DIR input.
   localparam logic LSB_FIRST = 1'b0;
   localparam logic MSB_FIRST = 1'b1;

   // Width of a counter that must be able to hold the value `width`.
   function automatic int cntWidth(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_deserializer_bit_counter.sv
// Bit counter for the deserializer. It counts enabled strobes, wraps to zero
// after the last bit of a word and flags that last bit combinationally.
// A clear that coincides with an enable restarts the count at one, since
// that strobe is itself the first bit of the new sequence.
module serial_deserializer_bit_counter
   import serial_deserializer_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = cntWidth(WIDTH)
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_terminal
);

   logic [CNT_W-1:0] r_count;

   assign o_terminal = (r_count == CNT_W'(WIDTH - 1)) && i_en;

   // Count register: clear has priority, otherwise advance or wrap on enable.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= i_en ? CNT_W'(1) : '0;
      end else if (i_en) begin
         r_count <= o_terminal ? '0 : r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver. Samples a serial stream on ENB strobes,
// rebuilds WIDTH-bit words in either bit order and hands each finished
// word to a consumer through a VALID/ACK handshake, flagging words that
// had to be dropped because the previous one was never taken.
module serial_deserializer
   import serial_deserializer_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = cntWidth(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_dir,
   input  logic             i_enb,
   input  logic             i_s_in,
   input  logic             i_ack,
   output logic [WIDTH-1:0] o_q,
   output logic             o_valid,
   output logic             o_busy,
   output logic             o_overrun
);

   state_t           r_state;
   state_t           w_stateNext;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shiftBase;
   logic [WIDTH-1:0] w_shifted;
   logic [WIDTH-1:0] w_shiftNext;
   logic             w_shiftDir;
   logic             r_dir;
   logic [WIDTH-1:0] r_q;
   logic             r_valid;
   logic             r_busy;
   logic             r_overrun;
   logic             w_sample;
   logic             w_terminal;
   logic             w_complete;
   logic             w_clr;

   // A bit is taken in RECV, or in IDLE when START opens the frame that cycle.
   assign w_sample   = i_enb && ((r_state == ST_RECV) || i_start);
   assign w_complete = w_terminal && (r_state == ST_RECV);
   // START restarts the frame, except on a completing edge where the
   // completing bit belongs to the old word and the new frame starts empty.
   assign w_clr      = i_start && !w_complete;

   serial_deserializer_bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bitCounter (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clr      (w_clr),
      .i_en       (w_sample),
      .o_terminal (w_terminal)
   );

   // Next-state logic: START always lands in RECV, completion returns to IDLE.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_stateNext = ST_RECV;
            end
         end
         ST_RECV: begin
            if (i_start) begin
               w_stateNext = ST_RECV;
            end else if (w_complete) begin
               w_stateNext = ST_IDLE;
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase
   end

   // Shift datapath: pick the base word and bit order, shift in S_IN, and
   // decide what the shift register holds after this edge.
   always_comb begin
      w_shiftBase = r_shift;
      w_shiftDir  = r_dir;
      if (w_clr) begin
         w_shiftBase = '0;
         w_shiftDir  = i_dir;
      end
      w_shifted = w_shiftBase;
      case (w_shiftDir)
         LSB_FIRST: w_shifted = {i_s_in, w_shiftBase[WIDTH-1:1]};
         MSB_FIRST: w_shifted = {w_shiftBase[WIDTH-2:0], i_s_in};
         default:   w_shifted = w_shiftBase;
      endcase
      w_shiftNext = r_shift;
      if (w_complete) begin
         w_shiftNext = '0;
      end else if (w_sample) begin
         w_shiftNext = w_shifted;
      end else if (w_clr) begin
         w_shiftNext = '0;
      end
   end

   // State, shift register and handshake outputs, all held in flops.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_dir     <= LSB_FIRST;
         r_q       <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_busy  <= (w_stateNext == ST_RECV);
         r_shift <= w_shiftNext;
         if (i_start) begin
            r_dir <= i_dir;
         end
         if (w_complete) begin
            if (!r_valid || i_ack) begin
               r_q     <= w_shifted;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (i_ack) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_q       = r_q;
   assign o_valid   = r_valid;
   assign o_busy    = r_busy;
   assign o_overrun = r_overrun;

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer: directed frames with literal
// expectations, then random traffic compared every cycle to a queue-based
// model of the receive protocol.
module tb_serial_deserializer;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic         start;
   logic         dir;
   logic         enb;
   logic         sIn;
   logic         ack;
   logic [W-1:0] q;
   logic         valid;
   logic         busy;
   logic         overrun;

   int  compared   = 0;
   int  mismatched = 0;
   bit  cmpOn      = 0;

   // Model state: bits of the current frame in arrival order.
   bit  mBits[$];
   bit  mActive;
   bit  mDir;
   int  mQ;
   bit  mValid;
   bit  mOverrun;

   serial_deserializer #(.WIDTH(W)) dut (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_start   (start),
      .i_dir     (dir),
      .i_enb     (enb),
      .i_s_in    (sIn),
      .i_ack     (ack),
      .o_q       (q),
      .o_valid   (valid),
      .o_busy    (busy),
      .o_overrun (overrun)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one value against its expectation and keep the tallies.
   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Hold one set of inputs across one rising edge, then release 2 units later.
   task automatic applyStimulus(input bit rst, input bit st, input bit d,
                                input bit e, input bit s, input bit a);
      reset = rst;
      start = st;
      dir   = d;
      enb   = e;
      sIn   = s;
      ack   = a;
      @(posedge clk);
      #2;
   endtask

   // Send a full word back to back, START on the first bit.
   task automatic sendWord(input int word, input bit d, input bit ackLast);
      bit b;
      for (int i = 0; i < W; i++) begin
         b = d ? bit'((word >> (W - 1 - i)) & 1) : bit'((word >> i) & 1);
         applyStimulus(0, i == 0, d, 1, b, ackLast && (i == W - 1));
      end
   endtask

   task automatic idleCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   // Reference model: tracks the frame as a list of received bits and
   // assembles the word arithmetically once W bits have arrived.
   always @(posedge clk) begin
      bit completing;
      int word;
      if (reset) begin
         mBits.delete();
         mActive  = 0;
         mDir     = 0;
         mQ       = 0;
         mValid   = 0;
         mOverrun = 0;
      end else begin
         completing = mActive && enb && (mBits.size() == W - 1);
         if (completing) begin
            mBits.push_back(sIn);
            word = 0;
            for (int i = 0; i < W; i++) begin
               if (mBits[i]) word += mDir ? (1 << (W - 1 - i)) : (1 << i);
            end
            if (!mValid || ack) begin
               mQ     = word;
               mValid = 1;
            end else begin
               mOverrun = 1;
            end
            mBits.delete();
            mActive = 0;
         end else if (ack) begin
            mValid = 0;
         end
         if (start) begin
            mActive = 1;
            mDir    = dir;
            mBits.delete();
            if (enb && !completing) mBits.push_back(sIn);
         end else if (mActive && enb && !completing) begin
            mBits.push_back(sIn);
         end
      end
   end

   // Every-cycle comparison of the DUT outputs against the model.
   always @(negedge clk) begin
      if (cmpOn) begin
         checkOutput("cyc_q", int'(q), mQ);
         checkOutput("cyc_valid", int'(valid), int'(mValid));
         checkOutput("cyc_busy", int'(busy), int'(mActive));
         checkOutput("cyc_overrun", int'(overrun), int'(mOverrun));
      end
   end

   // Directed scenarios followed by random traffic.
   initial begin
      $display("[TB] serial_deserializer bench start");
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      cmpOn = 1;
      checkOutput("reset_q", int'(q), 0);
      checkOutput("reset_valid", int'(valid), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_overrun", int'(overrun), 0);

      // LSB first, bits 1,1,0,1 -> B
      applyStimulus(0, 1, 0, 1, 1, 0);
      checkOutput("lsb_busy1", int'(busy), 1);
      applyStimulus(0, 0, 0, 1, 1, 0);
      checkOutput("lsb_busy2", int'(busy), 1);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("lsb_busy3", int'(busy), 1);
      checkOutput("lsb_valid3", int'(valid), 0);
      applyStimulus(0, 0, 0, 1, 1, 0);
      checkOutput("lsb_q", int'(q), 'hB);
      checkOutput("lsb_model_q", mQ, 'hB);
      checkOutput("lsb_valid", int'(valid), 1);
      checkOutput("lsb_busy4", int'(busy), 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("ack_valid", int'(valid), 0);

      // MSB first with two-cycle gaps, bits 1,0,0,1 -> 9
      applyStimulus(0, 1, 1, 1, 1, 0);
      idleCycle();
      idleCycle();
      checkOutput("gap_q", int'(q), 'hB);
      checkOutput("gap_busy", int'(busy), 1);
      applyStimulus(0, 0, 0, 1, 0, 0);
      idleCycle();
      idleCycle();
      applyStimulus(0, 0, 0, 1, 0, 0);
      idleCycle();
      idleCycle();
      checkOutput("gap_valid", int'(valid), 0);
      applyStimulus(0, 0, 0, 1, 1, 0);
      checkOutput("msb_q", int'(q), 'h9);
      checkOutput("msb_model_q", mQ, 'h9);
      checkOutput("msb_valid", int'(valid), 1);
      applyStimulus(0, 0, 0, 0, 0, 1);

      // Overrun: A unconsumed, then 5 arrives
      sendWord('hA, 0, 0);
      sendWord('h5, 1, 0);
      checkOutput("ovr_q", int'(q), 'hA);
      checkOutput("ovr_valid", int'(valid), 1);
      checkOutput("ovr_flag", int'(overrun), 1);
      checkOutput("ovr_model_flag", int'(mOverrun), 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("ovr_ack_valid", int'(valid), 0);
      checkOutput("ovr_sticky", int'(overrun), 1);
      applyStimulus(1, 0, 0, 0, 0, 0);

      // ACK coincident with completion
      sendWord('h3, 0, 0);
      sendWord('hC, 1, 1);
      checkOutput("ackc_q", int'(q), 'hC);
      checkOutput("ackc_valid", int'(valid), 1);
      checkOutput("ackc_overrun", int'(overrun), 0);
      applyStimulus(0, 0, 0, 0, 0, 1);

      // Restart: two bits, then START+DIR=1 with bits 0,1,1,1 -> 7
      applyStimulus(0, 1, 0, 1, 1, 0);
      applyStimulus(0, 0, 0, 1, 1, 0);
      sendWord('h7, 1, 0);
      checkOutput("restart_q", int'(q), 'h7);
      checkOutput("restart_model_q", mQ, 'h7);
      checkOutput("restart_busy", int'(busy), 0);

      // Reset mid-frame, then ENB without START
      applyStimulus(0, 1, 0, 1, 1, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 1, 1, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("mid_rst_q", int'(q), 0);
      checkOutput("mid_rst_valid", int'(valid), 0);
      checkOutput("mid_rst_busy", int'(busy), 0);
      checkOutput("mid_rst_overrun", int'(overrun), 0);
      applyStimulus(0, 0, 0, 1, 1, 0);
      checkOutput("idle_enb_busy", int'(busy), 0);
      checkOutput("idle_enb_valid", int'(valid), 0);

      // Random traffic checked each cycle by the compare process
      for (int n = 0; n < 3000; n++) begin
         applyStimulus($urandom_range(0, 149) == 0,
                       $urandom_range(0, 6) == 0,
                       bit'($urandom_range(0, 1)),
                       $urandom_range(0, 2) != 0,
                       bit'($urandom_range(0, 1)),
                       $urandom_range(0, 5) == 0);
      end

      cmpOn = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
